uart_rx_fifo_writer: RTL and testbench
======================================

Name: uart_rx_fifo_writer

Overview:
UART receiver on the WClk domain that deserialises the RxD line and pushes each received character into the RX FIFO write port (WData/WEn/Full). It sits directly upstream of the bridge's asynchronous RX FIFO; the APB side drains that FIFO on its own clock. The block recovers bit timing by oversampling, checks parity and framing, and reports sticky error status.

Parameters:
DATA_BITS, 8, character width; equals `DATA_WIDTH.
OVERSAMPLE, 16, oversample ticks per bit; even, at least 4.
DIV_WIDTH, 16, width of the BaudDiv input.

Ports:
WClk  in  1  clock; the FIFO write clock.
reset  in  1  synchronous, active-high.
BaudDiv  in  DIV_WIDTH  one oversample tick every BaudDiv+1 WClk cycles.
ParityEn  in  1  1 = one parity bit follows the data bits.
ParityOdd  in  1  1 = odd parity, 0 = even parity.
RxD  in  1  asynchronous serial input; idles high.
Full  in  1  FIFO full flag.
WData  out  DATA_BITS  received character to the FIFO.
WEn  out  1  one-cycle FIFO write strobe.
ErrClr  in  1  clears all sticky error flags.
ParityErr  out  1  sticky parity mismatch.
FrameErr  out  1  sticky stop bit sampled low.
Overrun  out  1  sticky: character dropped because Full was high.
Busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (already decided): reset is synchronous, active-high; all logic is clocked by WClk.
- Reset values: WData=0, WEn=0, all error flags=0, Busy=0, state=IDLE. The synchroniser flops reset to 1. The tick counter resets to 0.
- Synchroniser: RxD passes through a 2-flop synchroniser; rxs is the second flop's output.
- Tick generator: a free-running counter runs 0..BaudDiv. tick=1 in the cycle the counter equals BaudDiv, and the counter then wraps to 0. BaudDiv=0 gives a tick every cycle.
- Sample counter: sc, width log2(OVERSAMPLE), advances on tick. Bit sampling happens at sc==OVERSAMPLE/2-1 (mid-bit).
- State machine, transitions only on tick:
  - IDLE: when rxs==0, clear sc and go to START.
  - START: at mid-bit, if rxs==1 it is a glitch: go to IDLE with no write. Otherwise clear sc and go to DATA.
  - DATA: sample every OVERSAMPLE ticks, shifting LSB first. After DATA_BITS samples, go to PARITY if ParityEn=1, else STOP.
  - PARITY: sample once. Expected bit = XOR of data bits, XOR ParityOdd. A mismatch latches perr_pending.
  - STOP: sample once. If rxs==1 and Full==0: WData<=shift register and WEn=1 for exactly one cycle, in the WClk cycle after the stop sample tick. If rxs==1 and Full==1: no write, Overrun<=1. If rxs==0: no write, FrameErr<=1, go to BREAK. Otherwise go to IDLE immediately after the stop sample, so a start bit in the second half of the stop bit is caught.
  - BREAK: wait until rxs==1 on a tick, then go to IDLE. A held-low line never produces further characters.
- Parity error handling: ParityErr is set together with the write/overrun decision. The character is still written when it is otherwise valid.
- Full is sampled only in the stop decision cycle. WEn is never asserted while Full=1.
- WData holds its value between writes.
- ParityEn/ParityOdd/BaudDiv are sampled live. Changing them mid-frame is unsupported; the result is undefined but the block must not lock up.
- Sticky flags: ErrClr clears ParityErr, FrameErr and Overrun. If ErrClr coincides with a new error event, set wins.
- Reset mid-frame aborts the frame, with no write and no flags set.
- Latency: from the mid-stop-bit rxs sample, WEn follows after 1 WClk cycle. Add 2 cycles of synchroniser delay relative to raw RxD.

Test Plan:
1. BaudDiv=0, ParityEn=0; RxD frame 0xA5, 16 clocks per bit -> exactly one WEn pulse, WData=0xA5; ParityErr, FrameErr and Overrun all 0; Busy back to 0.
2. RxD low for 4 clocks then high (BaudDiv=0) -> no WEn; state back to IDLE before tick 8. A following valid 0x12 frame is received correctly.
3. ParityEn=1, ParityOdd=0; frame 0x3C with parity bit 1 (wrong) -> WEn with WData=0x3C, ParityErr=1. Pulse ErrClr -> ParityErr=0. Frame 0x3C with parity bit 0 -> no error.
4. Full=1 throughout frame 0x55 -> no WEn, Overrun=1. Full=0 for the next frame 0x66 -> WEn with WData=0x66, Overrun stays 1 until ErrClr.
5. Frame 0x81 with stop bit 0, then RxD held low for 40 bit times -> no WEn, FrameErr=1, no further frames. RxD high, then frame 0x42 -> WData=0x42.
6. reset pulsed during data bit 4 of a frame -> all outputs at reset values, no WEn. Next full frame 0x7E -> WData=0x7E. BaudDiv=3 variant: bit period is 64 clocks, same result.

Source files
------------

// File: rtl/uart_rx_fifo_writer.sv
// UART receiver feeding the RX FIFO write port on the WClk domain.
// Oversampled bit recovery, optional parity, stop-bit framing check and
// sticky error reporting (parity, framing, overrun).
module uart_rx_fifo_writer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                 WClk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] BaudDiv,
  input  logic                 ParityEn,
  input  logic                 ParityOdd,
  input  logic                 RxD,
  input  logic                 Full,
  output logic [DATA_BITS-1:0] WData,
  output logic                 WEn,
  input  logic                 ErrClr,
  output logic                 ParityErr,
  output logic                 FrameErr,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int unsigned SC_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rxs;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 tick;
  logic [SC_W-1:0]      sc, sc_n, sc_inc;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 perr_pending, perr_n;
  logic                 do_write, do_ovr, do_fe, do_pe;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge WClk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rxs     <= rx_meta;
    end
  end

  // >= rather than == so a live BaudDiv reduction cannot strand the counter.
  assign tick = (div_cnt >= BaudDiv);

  // Free-running oversample tick divider.
  always_ff @(posedge WClk) begin
    if (reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  assign sc_inc = (sc == SC_LAST) ? '0 : sc + 1'b1;

  // After the start bit re-aligns sc at mid-bit, later bits are sampled each
  // time sc completes a full OVERSAMPLE period, i.e. again at mid-bit.
  // Next-state and frame datapath decisions, evaluated on ticks only.
  always_comb begin
    state_n   = state;
    sc_n      = sc;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    perr_n    = perr_pending;
    do_write  = 1'b0;
    do_ovr    = 1'b0;
    do_fe     = 1'b0;
    do_pe     = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            sc_n    = '0;
            perr_n  = 1'b0;
            state_n = S_START;
          end
        end
        S_START: begin
          if (sc == SC_MID) begin
            if (rxs) begin
              state_n = S_IDLE;
            end else begin
              sc_n      = '0;
              bit_cnt_n = '0;
              state_n   = S_DATA;
            end
          end else begin
            sc_n = sc_inc;
          end
        end
        S_DATA: begin
          sc_n = sc_inc;
          if (sc == SC_LAST) begin
            shift_n   = {rxs, shift[DATA_BITS-1:1]};
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt == BC_LAST) state_n = ParityEn ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          sc_n = sc_inc;
          if (sc == SC_LAST) begin
            if (rxs != (^shift ^ ParityOdd)) perr_n = 1'b1;
            state_n = S_STOP;
          end
        end
        S_STOP: begin
          sc_n = sc_inc;
          if (sc == SC_LAST) begin
            if (rxs) begin
              if (Full) do_ovr   = 1'b1;
              else      do_write = 1'b1;
              do_pe   = perr_pending;
              state_n = S_IDLE;
            end else begin
              do_fe   = 1'b1;
              state_n = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxs) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Frame state and datapath registers.
  always_ff @(posedge WClk) begin
    if (reset) begin
      state        <= S_IDLE;
      sc           <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      perr_pending <= 1'b0;
    end else begin
      state        <= state_n;
      sc           <= sc_n;
      bit_cnt      <= bit_cnt_n;
      shift        <= shift_n;
      perr_pending <= perr_n;
    end
  end

  // FIFO write strobe/data and sticky error flags (a new event beats ErrClr).
  always_ff @(posedge WClk) begin
    if (reset) begin
      WData     <= '0;
      WEn       <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      WEn <= do_write;
      if (do_write) WData <= shift;
      ParityErr <= do_pe  | (ParityErr & ~ErrClr);
      FrameErr  <= do_fe  | (FrameErr  & ~ErrClr);
      Overrun   <= do_ovr | (Overrun   & ~ErrClr);
    end
  end

  assign Busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Self-checking bench for uart_rx_fifo_writer: a table of hand-derived frame
// vectors, directed multi-cycle corner cases, and random frames checked
// against a frame-level reference model.
module tb_uart_rx_fifo_writer;

  logic        WClk = 1'b0;
  logic        reset;
  logic [15:0] BaudDiv;
  logic        ParityEn, ParityOdd, RxD, Full, ErrClr;
  logic [7:0]  WData;
  logic        WEn, ParityErr, FrameErr, Overrun, Busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wen_cnt  = 0;
  int last_wen_cyc = 0;
  int frame_start  = 0;

  // Reference model state: last written character and sticky flags.
  logic [7:0] m_wdata;
  logic       m_pe, m_fe, m_ovr;

  typedef struct {
    logic [7:0] d;
    bit         pen, podd, pbad, full, stopb;
    int         baud;
    int         exp_wen;
    logic [7:0] exp_wdata;
    bit         exp_pe, exp_fe, exp_ovr;
  } vec_t;

  vec_t vecs[10];

  uart_rx_fifo_writer #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut (
    .WClk(WClk), .reset(reset), .BaudDiv(BaudDiv), .ParityEn(ParityEn),
    .ParityOdd(ParityOdd), .RxD(RxD), .Full(Full), .WData(WData), .WEn(WEn),
    .ErrClr(ErrClr), .ParityErr(ParityErr), .FrameErr(FrameErr),
    .Overrun(Overrun), .Busy(Busy)
  );

  always #5 WClk = ~WClk;

  always @(posedge WClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Count write strobes; a strobe must never appear while Full is high.
  always @(negedge WClk) begin
    if (!reset && WEn === 1'b1) begin
      wen_cnt++;
      last_wen_cyc = cyc;
      check("wen_while_full", {31'b0, Full}, 32'd0);
    end
  end

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge WClk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int clks);
    RxD = b;
    clocks(clks);
  endtask

  function automatic logic par_bit(input logic [7:0] d, input logic odd);
    return (($countones(d) % 2) == 1) ^ odd;
  endfunction

  task automatic clear_errs();
    ErrClr = 1'b1;
    clocks(1);
    ErrClr = 1'b0;
    m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
  endtask

  // Serialise one frame, then hold the line idle for two bit times.
  task automatic apply_frame(input logic [7:0] d, input bit pen, podd, pbad, full, stopb,
                             input int baud, output int nwen);
    int bclk;
    int w0;
    bclk = 16 * (baud + 1);
    BaudDiv = 16'(baud); ParityEn = pen; ParityOdd = podd; Full = full;
    w0 = wen_cnt;
    frame_start = cyc;
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
    if (pen) drive_bit(par_bit(d, podd) ^ pbad, bclk);
    drive_bit(stopb, bclk);
    drive_bit(1'b1, 2 * bclk);
    Full = 1'b0;
    nwen = wen_cnt - w0;
  endtask

  task automatic check_outputs(input string tag, input int nwen, input int exp_wen,
                               input logic [7:0] wd, input bit pe, fe, ovr);
    check({tag, "_wen_count"}, nwen, exp_wen);
    check({tag, "_wdata"}, WData, wd);
    check({tag, "_parity_err"}, ParityErr, pe);
    check({tag, "_frame_err"}, FrameErr, fe);
    check({tag, "_overrun"}, Overrun, ovr);
    check({tag, "_busy"}, Busy, 0);
  endtask

  // Frame-level model: a good stop bit writes or overruns (carrying any parity
  // error with it); a bad stop bit is a framing error only.
  task automatic model_frame(input string tag, input logic [7:0] d, input bit pen, podd,
                             pbad, full, stopb, input int baud);
    int nwen;
    int exp_wen;
    apply_frame(d, pen, podd, pbad, full, stopb, baud, nwen);
    exp_wen = 0;
    if (!stopb) begin
      m_fe = 1'b1;
    end else begin
      if (full) m_ovr = 1'b1;
      else begin
        m_wdata = d;
        exp_wen = 1;
      end
      if (pen && pbad) m_pe = 1'b1;
    end
    check_outputs(tag, nwen, exp_wen, m_wdata, m_pe, m_fe, m_ovr);
  endtask

  initial begin
    int nwen;
    int lat;
    reset = 1'b1; BaudDiv = '0; ParityEn = 1'b0; ParityOdd = 1'b0;
    RxD = 1'b1; Full = 1'b0; ErrClr = 1'b0;
    m_wdata = '0; m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;

    //                d      pen podd pbad full stop baud wen wdata  pe fe ov
    vecs[0] = '{8'hA5, 0, 0, 0, 0, 1, 0, 1, 8'hA5, 0, 0, 0};
    vecs[1] = '{8'h3C, 1, 0, 1, 0, 1, 0, 1, 8'h3C, 1, 0, 0};
    vecs[2] = '{8'h3C, 1, 0, 0, 0, 1, 0, 1, 8'h3C, 0, 0, 0};
    vecs[3] = '{8'h55, 0, 0, 0, 1, 1, 0, 0, 8'h3C, 0, 0, 1};
    vecs[4] = '{8'h81, 0, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 1, 0};
    vecs[5] = '{8'h0F, 1, 1, 0, 0, 1, 1, 1, 8'h0F, 0, 0, 0};
    vecs[6] = '{8'h0F, 1, 1, 1, 0, 1, 2, 1, 8'h0F, 1, 0, 0};
    vecs[7] = '{8'h00, 1, 0, 1, 1, 1, 0, 0, 8'h0F, 1, 0, 1};
    vecs[8] = '{8'hFF, 0, 0, 0, 0, 1, 3, 1, 8'hFF, 0, 0, 0};
    vecs[9] = '{8'h66, 1, 1, 0, 0, 1, 0, 1, 8'h66, 0, 0, 0};

    clocks(4);
    check("reset_wen", WEn, 0);
    check("reset_wdata", WData, 0);
    check("reset_flags", {ParityErr, FrameErr, Overrun}, 0);
    check("reset_busy", Busy, 0);
    reset = 1'b0;
    clocks(4);

    // Table-driven frames, each starting with cleared flags.
    for (int i = 0; i < 10; i++) begin
      clear_errs();
      check($sformatf("vec%0d_cleared", i), {ParityErr, FrameErr, Overrun}, 0);
      apply_frame(vecs[i].d, vecs[i].pen, vecs[i].podd, vecs[i].pbad, vecs[i].full,
                  vecs[i].stopb, vecs[i].baud, nwen);
      check_outputs($sformatf("vec%0d", i), nwen, vecs[i].exp_wen, vecs[i].exp_wdata,
                    vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_ovr);
      if (vecs[i].baud == 0 && vecs[i].exp_wen == 1) begin
        lat = last_wen_cyc - frame_start;
        check($sformatf("vec%0d_latency", i), lat, vecs[i].pen ? 171 : 155);
      end
      m_wdata = vecs[i].exp_wdata;
    end
    clear_errs();

    // Start-bit glitch: low for 4 clocks is rejected at the mid-start sample.
    BaudDiv = '0; ParityEn = 1'b0;
    nwen = wen_cnt;
    drive_bit(1'b0, 4);
    check("glitch_busy_seen", Busy, 1);
    drive_bit(1'b1, 8);
    check("glitch_back_idle", Busy, 0);
    clocks(32);
    check("glitch_no_wen", wen_cnt - nwen, 0);
    model_frame("after_glitch", 8'h12, 0, 0, 0, 0, 1, 0);

    // Overrun stays set across a later good write until cleared.
    model_frame("ovr_full", 8'h55, 0, 0, 0, 1, 1, 0);
    model_frame("ovr_next", 8'h66, 0, 0, 0, 0, 1, 0);
    clear_errs();
    check("ovr_cleared", Overrun, 0);

    // Break: bad stop bit and a line held low for 40 bit times.
    nwen = wen_cnt;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(m_wdata[0] ^ (i == 0 || i == 7), 0);
    RxD = 1'b0;
    for (int i = 0; i < 8; i++) drive_bit((8'h81 >> i) & 1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 40 * 16);
    check("break_no_wen", wen_cnt - nwen, 0);
    check("break_frame_err", FrameErr, 1);
    check("break_busy", Busy, 1);
    drive_bit(1'b1, 32);
    check("break_released", Busy, 0);
    m_fe = 1'b1;
    model_frame("after_break", 8'h42, 0, 0, 0, 0, 1, 0);
    clear_errs();

    // Reset in the middle of data bit 4 aborts the frame, at two baud rates.
    for (int b = 0; b < 2; b++) begin
      int bclk;
      bclk = (b == 0) ? 16 : 64;
      model_frame($sformatf("pre_reset%0d", b), 8'h99, 0, 0, 0, 1, 1, b * 3);
      BaudDiv = 16'(b * 3);
      nwen = wen_cnt;
      drive_bit(1'b0, bclk);
      for (int i = 0; i < 4; i++) drive_bit((8'h7E >> i) & 1, bclk);
      drive_bit(1'b1, bclk / 2);
      reset = 1'b1;
      clocks(1);
      reset = 1'b0;
      check($sformatf("rst%0d_wen", b), WEn, 0);
      check($sformatf("rst%0d_wdata", b), WData, 0);
      check($sformatf("rst%0d_flags", b), {ParityErr, FrameErr, Overrun}, 0);
      check($sformatf("rst%0d_busy", b), Busy, 0);
      drive_bit(1'b1, 2 * bclk);
      check($sformatf("rst%0d_no_wen", b), wen_cnt - nwen, 0);
      m_wdata = '0; m_pe = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
      model_frame($sformatf("post_reset%0d", b), 8'h7E, 0, 0, 0, 0, 1, b * 3);
    end

    // Random frames against the reference model.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      bit pen, podd, pbad, full, stopb;
      d     = 8'($urandom);
      pen   = 1'($urandom);
      podd  = 1'($urandom);
      pbad  = ($urandom_range(0, 2) == 0);
      full  = ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 1) == 1) clear_errs();
      model_frame($sformatf("rand%0d", i), d, pen, podd, pbad, full, stopb,
                  $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
